maze_game_ctrl: RTL and testbench

Game-flow controller for the memory-maze game. Sits between the button conditioner (single-cycle move/select pulses) and the VGA/SSD front end. Sequences menu, difficulty selection, timed map preview and play. Owns the player position and arbitrates every move through a registered read of the map ROM to detect wall collisions and the goal.

---
 rtl/maze_game_ctrl_if.sv | 32 +++
 rtl/maze_game_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_maze_game_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_game_ctrl_if.sv
// rtl/maze_game_ctrl_if.sv - Button, map ROM and display signals of the maze game controller
// master = controller side, slave = button conditioner / ROM / VGA-SSD side.
interface maze_game_ctrl_if #(
  parameter int MAP_W = 30,
  parameter int MAP_H = 21
);
  logic [3:0]               move_pulse;
  logic                     sel_pulse;
  logic [$clog2(MAP_H)-1:0] rom_addr;
  logic [MAP_W-1:0]         rom_data;
  logic [3:0]               game_state;
  logic [2:0]               menu_item;
  logic [2:0]               difficulty;
  logic                     show_instr;
  logic                     map_visible;
  logic [7:0]               player_x;
  logic [7:0]               player_y;
  logic [1:0]               lives;
  logic                     busy;

  modport master (
    input  move_pulse, sel_pulse, rom_data,
    output rom_addr, game_state, menu_item, difficulty, show_instr, map_visible,
           player_x, player_y, lives, busy
  );

  modport slave (
    output move_pulse, sel_pulse, rom_data,
    input  rom_addr, game_state, menu_item, difficulty, show_instr, map_visible,
           player_x, player_y, lives, busy
  );
endinterface

// File: rtl/maze_game_ctrl.sv
// rtl/maze_game_ctrl.sv - Memory-maze game flow: menu, timed preview, ROM-checked player moves
// Optional lives counter enabled by defining MAZE_GAME_CTRL_LIVES_EN.
module maze_game_ctrl #(
  parameter int          MAP_W     = 30,
  parameter int          MAP_H     = 21,
  parameter int          START_X   = 0,
  parameter int          START_Y   = 20,
  parameter int          GOAL_X    = 29,
  parameter int          GOAL_Y    = 0,
  parameter int unsigned SHOW_EASY = 300000000,
  parameter int unsigned SHOW_MED  = 150000000,
  parameter int unsigned SHOW_HARD = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  maze_game_ctrl_if.master bus
);
  localparam int         AW      = $clog2(MAP_H);
  localparam logic [7:0] X_MAX   = 8'(MAP_W - 1);
  localparam logic [7:0] Y_MAX   = 8'(MAP_H - 1);
  localparam logic [7:0] X_START = 8'(START_X);
  localparam logic [7:0] Y_START = 8'(START_Y);
  localparam logic [7:0] X_GOAL  = 8'(GOAL_X);
  localparam logic [7:0] Y_GOAL  = 8'(GOAL_Y);
`ifdef MAZE_GAME_CTRL_LIVES_EN
  localparam logic [1:0] LIVES_RST = 2'd3;
`else
  localparam logic [1:0] LIVES_RST = 2'd1;
`endif

  typedef enum logic [2:0] {MENU, INSTR, SHOW, PLAY, REQ, CHK, LOST, WON} state_e;

  state_e        state_q, state_d;
  logic [2:0]    menu_q, menu_d;
  logic [2:0]    diff_q, diff_d;
  logic [31:0]   timer_q, timer_d;
  logic [7:0]    px_q, px_d, py_q, py_d;
  logic [7:0]    cx_q, cx_d, cy_q, cy_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    lives_q, lives_d;

  logic             mv_up, mv_dn, mv_lt, mv_rt;
  logic [MAP_W-1:0] row_sh;
  logic             wall;
  logic [31:0]      show_len;
  logic [3:0]       gs;

  assign {mv_up, mv_dn, mv_lt, mv_rt} = bus.move_pulse;
  assign row_sh = bus.rom_data >> cx_q;
  assign wall   = row_sh[0];

  always_comb begin
    if (diff_q[2])      show_len = SHOW_HARD;
    else if (diff_q[1]) show_len = SHOW_MED;
    else                show_len = SHOW_EASY;
  end

  always_comb begin
    state_d = state_q;
    menu_d  = menu_q;
    diff_d  = diff_q;
    timer_d = timer_q;
    px_d    = px_q;
    py_d    = py_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    pend_d  = 1'b0;
    lives_d = lives_q;
    addr_d  = addr_q;

    unique case (state_q)
      MENU: begin
        if (mv_up)      menu_d = {menu_q[0], menu_q[2:1]};
        else if (mv_dn) menu_d = {menu_q[1:0], menu_q[2]};
        if (bus.sel_pulse) begin
          if (menu_q[0]) begin
            timer_d = show_len;
            px_d    = X_START;
            py_d    = Y_START;
            state_d = SHOW;
`ifdef MAZE_GAME_CTRL_LIVES_EN
            lives_d = 2'd3;
`endif
          end else if (menu_q[1]) begin
            diff_d = {diff_q[1:0], diff_q[2]};
          end else begin
            state_d = INSTR;
          end
        end
      end
      INSTR: begin
        if (bus.sel_pulse) state_d = MENU;
      end
      SHOW: begin
        timer_d = timer_q - 32'd1;
        if (timer_q <= 32'd1) begin
          timer_d = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        // The candidate row is launched to the ROM one cycle before REQ so the
        // registered ROM word is settled by the time CHK samples it.
        if (pend_q) begin
          state_d = REQ;
        end else if (mv_up) begin
          if (py_q != 8'd0) begin
            cx_d = px_q; cy_d = py_q - 8'd1; pend_d = 1'b1;
          end
        end else if (mv_dn) begin
          if (py_q < Y_MAX) begin
            cx_d = px_q; cy_d = py_q + 8'd1; pend_d = 1'b1;
          end
        end else if (mv_lt) begin
          if (px_q != 8'd0) begin
            cx_d = px_q - 8'd1; cy_d = py_q; pend_d = 1'b1;
          end
        end else if (mv_rt) begin
          if (px_q < X_MAX) begin
            cx_d = px_q + 8'd1; cy_d = py_q; pend_d = 1'b1;
          end
        end
      end
      REQ: begin
        state_d = CHK;
      end
      CHK: begin
        if (wall) begin
`ifdef MAZE_GAME_CTRL_LIVES_EN
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            px_d    = X_START;
            py_d    = Y_START;
            state_d = PLAY;
          end else begin
            lives_d = 2'd0;
            state_d = LOST;
          end
`else
          state_d = LOST;
`endif
        end else begin
          px_d    = cx_q;
          py_d    = cy_q;
          state_d = (cx_q == X_GOAL && cy_q == Y_GOAL) ? WON : PLAY;
        end
      end
      LOST, WON: begin
        if (bus.sel_pulse) begin
          px_d    = X_START;
          py_d    = Y_START;
          state_d = MENU;
        end
      end
    endcase

    if (pend_d)                                 addr_d = cy_d[AW-1:0];
    else if (state_d == REQ || state_d == CHK)  addr_d = addr_q;
    else                                        addr_d = py_d[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MENU;
      menu_q  <= 3'b001;
      diff_q  <= 3'b001;
      timer_q <= '0;
      px_q    <= X_START;
      py_q    <= Y_START;
      cx_q    <= X_START;
      cy_q    <= Y_START;
      pend_q  <= 1'b0;
      addr_q  <= Y_START[AW-1:0];
      lives_q <= LIVES_RST;
    end else begin
      state_q <= state_d;
      menu_q  <= menu_d;
      diff_q  <= diff_d;
      timer_q <= timer_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      lives_q <= lives_d;
    end
  end

  always_comb begin
    unique case (state_q)
      MENU, INSTR: gs = 4'b0001;
      LOST:        gs = 4'b0100;
      WON:         gs = 4'b1000;
      default:     gs = 4'b0010;
    endcase
  end

  assign bus.game_state  = gs;
  assign bus.menu_item   = menu_q;
  assign bus.difficulty  = diff_q;
  assign bus.show_instr  = (state_q == INSTR);
  assign bus.map_visible = (state_q == SHOW);
  assign bus.busy        = (state_q == REQ) || (state_q == CHK);
  assign bus.player_x    = px_q;
  assign bus.player_y    = py_q;
  assign bus.lives       = lives_q;
  assign bus.rom_addr    = addr_q;
endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb/tb_maze_game_ctrl.sv - Randomized self-checking bench for maze_game_ctrl
module tb_maze_game_ctrl;
  localparam int MAP_W = 30;
  localparam int MAP_H = 21;
  localparam int SX = 0, SY = 20, GX = 29, GY = 0;
  localparam int SHOW_E = 10, SHOW_M = 7, SHOW_H = 4;
  localparam int M_MENU = 0, M_INSTR = 1, M_PLAY = 2, M_LOST = 3, M_WON = 4;
`ifdef MAZE_GAME_CTRL_LIVES_EN
  localparam int LIVES0 = 3;
`else
  localparam int LIVES0 = 1;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  maze_game_ctrl_if #(.MAP_W(MAP_W), .MAP_H(MAP_H)) bus ();

  maze_game_ctrl #(
    .SHOW_EASY(SHOW_E), .SHOW_MED(SHOW_M), .SHOW_HARD(SHOW_H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  logic [MAP_W-1:0] map_mem [MAP_H];
  always @(posedge clk)
    bus.rom_data <= (int'(bus.rom_addr) < MAP_H) ? map_mem[bus.rom_addr] : '0;

  int m_st, m_item, m_diff, m_x, m_y, m_lives;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gs_exp(input int st);
    case (st)
      M_MENU, M_INSTR: return 1;
      M_PLAY:          return 2;
      M_LOST:          return 4;
      default:         return 8;
    endcase
  endfunction

  function automatic int show_len(input int d);
    return (d == 0) ? SHOW_E : (d == 1) ? SHOW_M : SHOW_H;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".state"}, bus.game_state, gs_exp(m_st));
    chk({tag, ".menu"}, bus.menu_item, 32'(1 << m_item));
    chk({tag, ".diff"}, bus.difficulty, 32'(1 << m_diff));
    chk({tag, ".instr"}, bus.show_instr, (m_st == M_INSTR) ? 1 : 0);
    chk({tag, ".vis"}, bus.map_visible, 0);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".x"}, bus.player_x, m_x);
    chk({tag, ".y"}, bus.player_y, m_y);
    chk({tag, ".lives"}, bus.lives, m_lives);
    chk({tag, ".addr"}, bus.rom_addr, m_y);
  endtask

  task automatic pulse(input logic [3:0] mv, input logic sel);
    bus.move_pulse = mv;
    bus.sel_pulse  = sel;
    @(negedge clk);
    bus.move_pulse = 4'b0;
    bus.sel_pulse  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.move_pulse = 4'b0;
    bus.sel_pulse  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_st = M_MENU; m_item = 0; m_diff = 0; m_x = SX; m_y = SY; m_lives = LIVES0;
    check_all("rst");
    reset_n = 1'b1;
  endtask

  task automatic gen_map(input int density);
    for (int r = 0; r < MAP_H; r++)
      for (int c = 0; c < MAP_W; c++)
        map_mem[r][c] = ($urandom_range(0, 99) < density);
    map_mem[SY][SX] = 1'b0;
    map_mem[GY][GX] = 1'b0;
  endtask

  task automatic menu_step(input logic [3:0] mv, input logic sel);
    int old;
    old = m_item;
    pulse(mv, sel);
    if (m_st == M_INSTR) begin
      if (sel) m_st = M_MENU;
    end else begin
      if (mv[3])      m_item = (m_item + 2) % 3;
      else if (mv[2]) m_item = (m_item + 1) % 3;
      if (sel && old == 1) m_diff = (m_diff + 1) % 3;
      if (sel && old == 2) m_st = M_INSTR;
    end
    check_all("menu");
  endtask

  task automatic start_game(input int d);
    int cnt;
    if (m_st == M_INSTR) menu_step(4'b0, 1'b1);
    while (m_item != 1) menu_step(4'b1000, 1'b0);
    while (m_diff != d) menu_step(4'b0, 1'b1);
    while (m_item != 0) menu_step(4'b1000, 1'b0);
    pulse(4'b0, 1'b1);
    chk("show.state", bus.game_state, 2);
    cnt = 0;
    while (bus.map_visible === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == show_len(d)) bus.move_pulse = 4'b1001;
      @(negedge clk);
      bus.move_pulse = 4'b0;
    end
    chk("show.len", cnt, show_len(d));
    m_st = M_PLAY; m_x = SX; m_y = SY; m_lives = LIVES0;
    check_all("play0");
    @(negedge clk);
    chk("show.drop", bus.busy, 0);
  endtask

  task automatic do_move(input logic [3:0] mv);
    int nx, ny;
    bit inb;
    nx = m_x; ny = m_y;
    if (mv[3])      ny = m_y - 1;
    else if (mv[2]) ny = m_y + 1;
    else if (mv[1]) nx = m_x - 1;
    else            nx = m_x + 1;
    inb = (nx >= 0) && (nx < MAP_W) && (ny >= 0) && (ny < MAP_H);
    pulse(mv, 1'b0);
    chk("mv.busy0", bus.busy, 0);
    if (inb) chk("mv.addr", bus.rom_addr, ny);
    @(negedge clk);
    chk("mv.busy1", bus.busy, inb ? 1 : 0);
    if ($urandom_range(0, 1) == 1) bus.move_pulse = 4'($urandom_range(1, 15));
    @(negedge clk);
    bus.move_pulse = 4'b0;
    chk("mv.busy2", bus.busy, inb ? 1 : 0);
    @(negedge clk);
    if (inb) begin
      if (map_mem[ny][nx]) begin
`ifdef MAZE_GAME_CTRL_LIVES_EN
        if (m_lives > 1) begin
          m_lives--; m_x = SX; m_y = SY;
        end else begin
          m_lives = 0; m_st = M_LOST;
        end
`else
        m_st = M_LOST;
`endif
      end else begin
        m_x = nx; m_y = ny;
        if (nx == GX && ny == GY) m_st = M_WON;
      end
    end
    check_all("move");
  endtask

  task automatic play_random(input int n);
    for (int k = 0; k < n && m_st == M_PLAY; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        pulse(4'b0, 1'b1);
        check_all("play.sel");
      end else begin
        do_move(4'($urandom_range(1, 15)));
      end
    end
  endtask

  task automatic end_game();
    if (m_st == M_LOST || m_st == M_WON) begin
      pulse(4'($urandom_range(1, 15)), 1'b0);
      check_all("end.ign");
      pulse(4'b0, 1'b1);
      m_st = M_MENU; m_x = SX; m_y = SY;
      check_all("end.menu");
    end else begin
      do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    reset_n = 1'b0;
    bus.move_pulse = 4'b0;
    bus.sel_pulse  = 1'b0;
    gen_map(0);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      if (r >= 4 && m_st == M_MENU && m_item == 0) r = 0;
      case (r)
        0: menu_step(4'b1000, 1'b0);
        1: menu_step(4'b0100, 1'b0);
        2: menu_step(4'b0010, 1'b0);
        3: menu_step(4'b0001, 1'b0);
        default: menu_step(4'b0, 1'b1);
      endcase
    end

    gen_map(25);
    map_mem[20][0] = 1'b0;
    map_mem[19][0] = 1'b0;
    map_mem[20][1] = 1'b1;
    start_game(0);
    do_move(4'b1001);
    do_move(4'b0100);
    do_move(4'b0010);
    do_move(4'b0100);
    do_move(4'b0001);
    play_random(40);
    end_game();

    for (int g = 0; g < 4; g++) begin
      gen_map(20);
      start_game($urandom_range(0, 2));
      play_random(80);
      end_game();
    end

    gen_map(0);
    start_game(2);
    for (int i = 0; i < 29; i++) do_move(4'b0001);
    for (int i = 0; i < 20; i++) do_move(4'b1000);
    chk("goal.state", bus.game_state, 8);
    end_game();

    start_game(1);
    pulse(4'b1000, 1'b0);
    @(negedge clk);
    chk("midmv.busy", bus.busy, 1);
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
